// File: rtl/sipo_deframer.sv
// Serial-in/parallel-out receive deframer: start bit, MSB-first payload, stop bit.
// Good words land in a one-entry valid/ready output register; bad stops and drops are flagged.
module sipo_deframer #(
  parameter int unsigned DATA_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bit_en,
  input  logic                  sin,
  output logic [DATA_WIDTH-1:1] y,
  output logic                  valid,
  input  logic                  ready,
  output logic                  frame_err,
  output logic                  overrun,
  input  logic                  err_clr
);

  localparam int unsigned    CntW    = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 2);

  typedef enum logic [1:0] {StIdle, StData, StStop} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:1] shift_q, shift_d;
  logic [DATA_WIDTH-1:1] y_q, y_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;
  logic                  good;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    good    = 1'b0;
    ferr_d  = 1'b0;
    if (bit_en) begin
      case (state_q)
        StIdle: begin
          if (!sin) begin
            state_d = StData;
            cnt_d   = '0;
          end
        end
        StData: begin
          shift_d = {shift_q[DATA_WIDTH-2:1], sin};
          // Counter saturates on the last payload bit instead of wrapping.
          if (cnt_q == CntLast) begin
            state_d = StStop;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StStop: begin
          // A zero stop bit is consumed here and never treated as a new start bit.
          state_d = StIdle;
          good    = sin;
          ferr_d  = ~sin;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    y_d     = y_q;
    valid_d = valid_q;
    if (good && (!valid_q || ready)) begin
      y_d     = shift_q;
      valid_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    // A new drop outranks a simultaneous clear.
    ovr_d = (good && valid_q && !ready) || (ovr_q && !err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign y         = y_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule
